// File: rtl/cpu_defs.sv
// Shared CPU definitions: address/exception/flush/prediction/MMU types and the
// fetch request record handed from the address generator to the IF stage.
// No ports (package).
package cpu_defs;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] phys_t;

  localparam logic [4:0] EXCCODE_TLBL = 5'h02;
  localparam logic [4:0] EXCCODE_TLBS = 5'h03;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;

  localparam virt_t EXC_VEC_REFILL  = 32'hbfc00200;
  localparam virt_t EXC_VEC_GENERAL = 32'hbfc00380;

  // Lane mask is sized for the widest legal fetch block; lanes at or above the
  // configured width always read zero.
  localparam int unsigned MAX_FETCH_WIDTH = 4;

  typedef struct packed {
    logic       ex;
    logic       tlb_refill;
    logic [4:0] exc_code;
    virt_t      badvaddr;
  } exception_t;

  typedef struct packed {
    logic ex;
    logic tlb_refill;
    logic eret;
    logic tlb_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic  valid;
    logic  br_taken;
    virt_t target;
  } predict_result_t;

  typedef struct packed {
    phys_t phy_addr;
  } mmu_result_t;

  typedef struct packed {
    logic                       valid;
    virt_t                      pc;
    logic [MAX_FETCH_WIDTH-1:0] lane_mask;
    exception_t                 exception;
  } fetch_req_t;

  // Lanes from the pc's slot to the end of its block are live.
  function automatic logic [MAX_FETCH_WIDTH-1:0] lane_mask_of(virt_t pc, int unsigned fw);
    logic [MAX_FETCH_WIDTH-1:0] mask;
    int unsigned                off;
    off  = 32'(pc[3:2]) & (fw - 1);
    mask = '0;
    for (int unsigned i = 0; i < MAX_FETCH_WIDTH; i++) begin
      mask[i] = (i < fw) && (i >= off);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fetch_inflight_ctr.sv
// In-flight instruction request tracker.
//   accept      : request accepted by memory this cycle (issue & addr_ok)
//   data_ok     : a response returns this cycle
//   redirect    : fetch stream redirected; everything in flight becomes stale
//   outstanding : number of accepted requests still awaiting data
//   full        : outstanding has reached MAX_OUTSTANDING
//   resp_keep   : current data_ok belongs to a request that is still wanted
module fetch_inflight_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             data_ok,
  input  logic             redirect,
  output logic [CNT_W-1:0] outstanding,
  output logic             full,
  output logic             resp_keep
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !data_ok) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && data_ok && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    discard_cnt_d = discard_cnt_q;
    if (redirect) begin
      // Post-cycle count: responses still owed after this edge are all stale.
      discard_cnt_d = cnt_d;
    end else if (data_ok && (discard_cnt_q != '0)) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      discard_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign outstanding = cnt_q;
  assign full        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign resp_keep   = !reset && data_ok && (discard_cnt_q == '0);

endmodule

// File: rtl/fetch_addr_gen.sv
// Instruction fetch address generator: holds the fetch pc, issues block-sized
// instruction requests, follows predictions and redirects, and emits a single
// exception record for an unfetchable pc.
//   clk, reset                  : clock, synchronous active-high reset
//   fs_allowin, bpu_flush       : IF ready / issue suppression
//   predict_result              : prediction for the block issued this cycle
//   is_correction/correct_target: branch redirect
//   pipeline_flush, c0_epc,
//   tlb_pc                      : exception / eret / TLB-op redirects
//   inst_vaddr, inst_result,
//   inst_tlb_ex                 : combinational MMU lookup of the current pc
//   inst_req/addr/size/addr_ok/
//   data_ok                     : instruction memory request channel
//   fs_req                      : request record to IF
//   resp_keep, outstanding      : response filtering and in-flight count
module fetch_addr_gen
  import cpu_defs::*;
#(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter virt_t       RESET_PC        = 32'hbfc00000,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_allowin,
  input  logic             bpu_flush,
  input  predict_result_t  predict_result,
  input  logic             is_correction,
  input  virt_t            correct_target,
  input  pipeline_flush_t  pipeline_flush,
  input  virt_t            c0_epc,
  input  virt_t            tlb_pc,
  output virt_t            inst_vaddr,
  input  mmu_result_t      inst_result,
  input  exception_t       inst_tlb_ex,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  output logic [1:0]       inst_size,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  output fetch_req_t       fs_req,
  output logic             resp_keep,
  output logic [CNT_W-1:0] outstanding
);

  localparam virt_t BLOCK_BYTES = virt_t'(4 * FETCH_WIDTH);

  virt_t      pc_q, pc_d;
  logic       pfs_valid_q;
  logic       ex_sent_q, ex_sent_d;
  logic       redirect, issue, accept, ex_record, full;
  virt_t      redirect_pc, seq_pc;
  exception_t exc;

  assign redirect = pipeline_flush.ex | pipeline_flush.eret | pipeline_flush.tlb_op |
                    is_correction;

  always_comb begin
    redirect_pc = correct_target;
    if (pipeline_flush.ex) begin
      redirect_pc = pipeline_flush.tlb_refill ? EXC_VEC_REFILL : EXC_VEC_GENERAL;
    end else if (pipeline_flush.eret) begin
      redirect_pc = c0_epc;
    end else if (pipeline_flush.tlb_op) begin
      redirect_pc = tlb_pc + 32'd4;
    end
  end

  // Misalignment wins over a TLB fault; refill only applies to load-side TLB misses.
  always_comb begin
    exc = '0;
    if (pc_q[1:0] != 2'b00) begin
      exc.ex       = 1'b1;
      exc.exc_code = EXCCODE_ADEL;
      exc.badvaddr = pc_q;
    end else if (inst_tlb_ex.ex) begin
      exc            = inst_tlb_ex;
      exc.tlb_refill = inst_tlb_ex.tlb_refill && (inst_tlb_ex.exc_code == EXCCODE_TLBL);
    end
  end

  assign issue = !reset && pfs_valid_q && !exc.ex && fs_allowin && !bpu_flush &&
                 !redirect && !full;
  assign accept = issue && inst_addr_ok;

  // Exception record waits for the memory side to go quiet, then fires once.
  assign ex_record = !reset && pfs_valid_q && exc.ex && !ex_sent_q &&
                     (outstanding == '0) && fs_allowin && !redirect;

  always_comb begin
    if (predict_result.valid && predict_result.br_taken) begin
      seq_pc = predict_result.target;
    end else begin
      seq_pc = (pc_q & ~(BLOCK_BYTES - 32'd1)) + BLOCK_BYTES;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    ex_sent_d = ex_sent_q;
    if (redirect) begin
      pc_d      = redirect_pc;
      ex_sent_d = 1'b0;
    end else begin
      if (accept) begin
        pc_d = seq_pc;
      end
      if (ex_record) begin
        ex_sent_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pfs_valid_q <= 1'b0;
      ex_sent_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pfs_valid_q <= 1'b1;
      ex_sent_q   <= ex_sent_d;
    end
  end

  fetch_inflight_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_inflight (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .data_ok    (inst_data_ok),
    .redirect   (redirect),
    .outstanding(outstanding),
    .full       (full),
    .resp_keep  (resp_keep)
  );

  assign inst_req   = issue;
  assign inst_vaddr = pc_q;
  assign inst_addr  = inst_result.phy_addr;
  assign inst_size  = 2'd2;

  always_comb begin
    fs_req           = '0;
    fs_req.valid     = accept || ex_record;
    fs_req.pc        = pc_q;
    fs_req.lane_mask = lane_mask_of(pc_q, FETCH_WIDTH);
    if (ex_record) begin
      fs_req.exception = exc;
    end
  end

endmodule

// File: tb/tb_fetch_addr_gen.sv
`timescale 1ns/1ps
module tb_fetch_addr_gen;
  import cpu_defs::*;

  localparam int unsigned FW    = 2;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned CNT_W = $clog2(MAXO + 1);
  localparam virt_t       RPC   = 32'hbfc00000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fs_allowin = 1'b0;
  logic            bpu_flush = 1'b0;
  predict_result_t predict_result = '0;
  logic            is_correction = 1'b0;
  virt_t           correct_target = '0;
  pipeline_flush_t pipeline_flush = '0;
  virt_t           c0_epc = '0;
  virt_t           tlb_pc = '0;
  virt_t           inst_vaddr;
  mmu_result_t     inst_result;
  exception_t      inst_tlb_ex = '0;
  logic            inst_req;
  logic [31:0]     inst_addr;
  logic [1:0]      inst_size;
  logic            inst_addr_ok = 1'b1;
  logic            inst_data_ok = 1'b0;
  fetch_req_t      fs_req;
  logic            resp_keep;
  logic [CNT_W-1:0] outstanding;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Simple fixed translation: strip the kseg bits.
  assign inst_result.phy_addr = {3'b000, inst_vaddr[28:0]};

  fetch_addr_gen #(
    .FETCH_WIDTH    (FW),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC       (RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fs_allowin    (fs_allowin),
    .bpu_flush     (bpu_flush),
    .predict_result(predict_result),
    .is_correction (is_correction),
    .correct_target(correct_target),
    .pipeline_flush(pipeline_flush),
    .c0_epc        (c0_epc),
    .tlb_pc        (tlb_pc),
    .inst_vaddr    (inst_vaddr),
    .inst_result   (inst_result),
    .inst_tlb_ex   (inst_tlb_ex),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_size     (inst_size),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .fs_req        (fs_req),
    .resp_keep     (resp_keep),
    .outstanding   (outstanding)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight requests kept as a FIFO of "still wanted" flags.
  virt_t m_pc;
  bit    m_valid;
  bit    m_sent;
  bit    m_ready = 1'b0;
  bit    m_q[$];

  function automatic bit m_redirect();
    return pipeline_flush.ex || pipeline_flush.eret || pipeline_flush.tlb_op || is_correction;
  endfunction

  function automatic virt_t m_target();
    if (pipeline_flush.ex) return pipeline_flush.tlb_refill ? 32'hbfc00200 : 32'hbfc00380;
    if (pipeline_flush.eret) return c0_epc;
    if (pipeline_flush.tlb_op) return tlb_pc + 4;
    return correct_target;
  endfunction

  function automatic exception_t m_exc();
    exception_t e;
    e = '0;
    if (m_pc % 4 != 0) begin
      e.ex       = 1'b1;
      e.exc_code = 5'h04;
      e.badvaddr = m_pc;
    end else if (inst_tlb_ex.ex) begin
      e            = inst_tlb_ex;
      e.tlb_refill = inst_tlb_ex.tlb_refill && (inst_tlb_ex.exc_code == 5'h02);
    end
    return e;
  endfunction

  function automatic bit m_issue();
    return !reset && m_valid && !m_exc().ex && fs_allowin && !bpu_flush && !m_redirect() &&
           (m_q.size() < MAXO);
  endfunction

  function automatic bit m_record();
    return !reset && m_valid && m_exc().ex && !m_sent && (m_q.size() == 0) && fs_allowin &&
           !m_redirect();
  endfunction

  function automatic logic [3:0] m_mask(virt_t pc);
    logic [3:0] m;
    int         off;
    off = int'((pc / 4) % FW);
    for (int i = 0; i < 4; i++) m[i] = (i < int'(FW)) && (i >= off);
    return m;
  endfunction

  function automatic int m_stale();
    int n;
    n = 0;
    foreach (m_q[i]) if (!m_q[i]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc    = RPC;
      m_valid = 1'b0;
      m_sent  = 1'b0;
      m_q.delete();
      m_ready = 1'b1;
    end else if (m_ready) begin
      bit    acc, rec, rd;
      virt_t tgt;
      acc = m_issue() && inst_addr_ok;
      rec = m_record();
      rd  = m_redirect();
      tgt = m_target();
      if (acc) m_q.push_back(1'b1);
      if (inst_data_ok && m_q.size() > 0) void'(m_q.pop_front());
      if (rd) foreach (m_q[i]) m_q[i] = 1'b0;
      if (rd) m_pc = tgt;
      else if (acc) m_pc = (predict_result.valid && predict_result.br_taken) ?
                           predict_result.target : m_pc - m_pc % (4 * FW) + 4 * FW;
      if (rd) m_sent = 1'b0;
      else if (rec) m_sent = 1'b1;
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      bit iss, rec, keep;
      iss  = m_issue();
      rec  = m_record();
      keep = !reset && inst_data_ok && (m_q.size() == 0 || m_q[0]);
      check("m_inst_req", inst_req, iss);
      check("m_inst_size", inst_size, 2'd2);
      check("m_inst_vaddr", inst_vaddr, m_pc);
      check("m_inst_addr", inst_addr, {3'b000, m_pc[28:0]});
      check("m_fs_valid", fs_req.valid, (iss && inst_addr_ok) || rec);
      check("m_outstanding", outstanding, m_q.size());
      check("m_resp_keep", resp_keep, keep);
      check("m_discard_cnt", dut.u_inflight.discard_cnt_q, m_stale());
      if ((iss && inst_addr_ok) || rec) begin
        check("m_fs_pc", fs_req.pc, m_pc);
        check("m_fs_mask", fs_req.lane_mask, m_mask(m_pc));
        check("m_fs_exc", fs_req.exception, rec ? m_exc() : exception_t'('0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    inst_data_ok = 1'b1;
    while (outstanding != 0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    inst_data_ok = 1'b0;
    check("drain_bounded", outstanding, 0);
  endtask

  initial begin
    int cnt;
    bit found;

    // Reset state, with a stray data_ok that must not be kept.
    reset = 1'b1;
    fs_allowin = 1'b1;
    inst_data_ok = 1'b1;
    tick();
    tick();
    #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_inst_req", inst_req, 0);
    check("rst_fs_valid", fs_req.valid, 0);
    check("rst_resp_keep", resp_keep, 0);
    inst_data_ok = 1'b0;
    tick();
    reset = 1'b0;

    // First requests after reset.
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      tick();
      #1;
      found = inst_req;
    end
    check("first_req_seen", found, 1);
    check("first_pc", inst_vaddr, 32'hbfc00000);
    check("first_addr", inst_addr, 32'h1fc00000);
    check("first_mask", fs_req.lane_mask, 4'b0011);
    check("first_fs_valid", fs_req.valid, 1);
    tick();
    #1;
    check("second_req", inst_req, 1);
    check("second_pc", inst_vaddr, 32'hbfc00008);
    check("one_outstanding", outstanding, 1);
    tick();
    fs_allowin = 1'b0;
    #1;
    check("two_outstanding", outstanding, 2);
    check("hold_no_req", inst_req, 0);
    drain();

    // Branch correction into the middle of a block.
    fs_allowin = 1'b1;
    is_correction = 1'b1;
    correct_target = 32'h80000004;
    #1;
    check("corr_suppress", inst_req, 0);
    tick();
    is_correction = 1'b0;
    #1;
    check("corr_req", inst_req, 1);
    check("corr_pc", inst_vaddr, 32'h80000004);
    check("corr_mask", fs_req.lane_mask, 4'b0010);
    tick();
    #1;
    check("corr_next_pc", inst_vaddr, 32'h80000008);
    check("corr_next_mask", fs_req.lane_mask, 4'b0011);
    tick();
    fs_allowin = 1'b0;
    #1;
    drain();

    // Outstanding limit with no responses.
    fs_allowin = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (inst_req && inst_addr_ok) cnt++;
      tick();
    end
    #1;
    check("limit_accepts", cnt, 4);
    check("limit_no_req", inst_req, 0);
    check("limit_outstanding", outstanding, 4);

    // First response frees a slot; then issue + data_ok in one cycle.
    inst_data_ok = 1'b1;
    #1;
    check("full_keep", resp_keep, 1);
    check("full_no_req", inst_req, 0);
    tick();
    #1;
    check("after_resp_outstanding", outstanding, 3);
    check("both_req", inst_req, 1);
    check("both_keep", resp_keep, 1);
    tick();
    inst_data_ok = 1'b0;
    fs_allowin = 1'b0;
    #1;
    check("both_outstanding", outstanding, 3);

    // General exception flush with three in flight.
    fs_allowin = 1'b1;
    pipeline_flush.ex = 1'b1;
    #1;
    check("flush_suppress", inst_req, 0);
    tick();
    pipeline_flush = '0;
    fs_allowin = 1'b0;
    #1;
    check("flush_discard", dut.u_inflight.discard_cnt_q, 3);
    inst_data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("flush_drop", resp_keep, 0);
      tick();
    end
    inst_data_ok = 1'b0;
    fs_allowin = 1'b1;
    #1;
    check("flush_req", inst_req, 1);
    check("flush_pc", inst_vaddr, 32'hbfc00380);
    check("flush_drained", outstanding, 0);

    // Two in flight, then correction to a misaligned target.
    tick();
    tick();
    is_correction = 1'b1;
    correct_target = 32'h80000002;
    #1;
    check("adel_corr_suppress", inst_req, 0);
    tick();
    is_correction = 1'b0;
    #1;
    check("adel_wait_no_req", inst_req, 0);
    check("adel_wait_no_rec", fs_req.valid, 0);
    check("adel_discard", dut.u_inflight.discard_cnt_q, 2);
    inst_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("adel_drop", resp_keep, 0);
      check("adel_hold", fs_req.valid, 0);
      tick();
    end
    inst_data_ok = 1'b0;
    #1;
    check("adel_rec", fs_req.valid, 1);
    check("adel_ex", fs_req.exception.ex, 1);
    check("adel_code", fs_req.exception.exc_code, 5'h04);
    check("adel_badvaddr", fs_req.exception.badvaddr, 32'h80000002);
    check("adel_no_req", inst_req, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      if (fs_req.valid) cnt++;
    end
    check("adel_once", cnt, 0);

    // eret beats a simultaneous correction; TLBL refill passes through.
    pipeline_flush.eret = 1'b1;
    c0_epc = 32'h00400000;
    is_correction = 1'b1;
    correct_target = 32'h12345678;
    tick();
    pipeline_flush = '0;
    is_correction = 1'b0;
    inst_tlb_ex.ex = 1'b1;
    inst_tlb_ex.tlb_refill = 1'b1;
    inst_tlb_ex.exc_code = 5'h02;
    inst_tlb_ex.badvaddr = 32'h00400000;
    #1;
    check("eret_pc", inst_vaddr, 32'h00400000);
    check("tlbl_rec", fs_req.valid, 1);
    check("tlbl_refill", fs_req.exception.tlb_refill, 1);
    check("tlbl_no_req", inst_req, 0);

    // TLB-op redirect; refill flag dropped for a non-TLBL code.
    tlb_pc = 32'h00400000;
    pipeline_flush.tlb_op = 1'b1;
    tick();
    pipeline_flush = '0;
    inst_tlb_ex.exc_code = 5'h03;
    #1;
    check("tlbop_pc", inst_vaddr, 32'h00400004);
    check("tlbs_rec", fs_req.valid, 1);
    check("tlbs_refill", fs_req.exception.tlb_refill, 0);

    // Refill exception beats tlb_op.
    pipeline_flush.ex = 1'b1;
    pipeline_flush.tlb_refill = 1'b1;
    pipeline_flush.tlb_op = 1'b1;
    tick();
    pipeline_flush = '0;
    inst_tlb_ex = '0;
    #1;
    check("refill_req", inst_req, 1);
    check("refill_pc", inst_vaddr, 32'hbfc00200);

    // Predictions and bpu_flush.
    predict_result.valid = 1'b1;
    predict_result.br_taken = 1'b1;
    predict_result.target = 32'h80001000;
    tick();
    predict_result.br_taken = 1'b0;
    predict_result.target = 32'h90000000;
    #1;
    check("taken_pc", inst_vaddr, 32'h80001000);
    tick();
    predict_result = '0;
    bpu_flush = 1'b1;
    #1;
    check("not_taken_pc", inst_vaddr, 32'h80001008);
    check("bpu_flush_no_req", inst_req, 0);
    tick();
    bpu_flush = 1'b0;
    #1;
    check("bpu_flush_hold_pc", inst_vaddr, 32'h80001008);
    check("bpu_flush_resume", inst_req, 1);
    fs_allowin = 1'b0;
    drain();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
